// File: rtl/mem_port_arbiter.sv
// Arbitrates the single synchronous memory port between fetch, data and stack
// requesters; owns the stack pointer and tags one-cycle-late read data to its owner.
module mem_port_arbiter #(
   parameter int              AW       = 10,
   parameter int              DW       = 16,
   parameter logic [AW-1:0]   SP_INIT  = 10'h3FF,
   parameter logic [AW-1:0]   SP_LIMIT = 10'h380,
   parameter int              MAX_WAIT = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          fetch_req,
   input  logic [AW-1:0] fetch_addr,
   output logic          fetch_gnt,
   output logic          fetch_valid,
   input  logic          data_req,
   input  logic          data_we,
   input  logic [AW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic          data_gnt,
   output logic          data_valid,
   input  logic          psh,
   input  logic          pop,
   input  logic [DW-1:0] stk_wdata,
   output logic          stk_gnt,
   output logic          stk_valid,
   output logic          stk_err,
   output logic [AW-1:0] SP,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int            WCW      = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
   localparam logic [AW-1:0] SP_FULL  = SP_LIMIT - 1'b1;

   // owner_q names who receives the read data returning this cycle
   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA, OWN_STK} owner_t;

   owner_t         owner_q, owner_d;
   logic [AW-1:0]  sp_q, sp_d;
   logic [WCW-1:0] wait_q, wait_d;
   logic           err_q, err_d;
   logic           push_ok, pop_ok;

   always_ff @(posedge clk) begin
      if (!reset) begin
         owner_q <= OWN_NONE;
         sp_q    <= SP_INIT;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         owner_q <= owner_d;
         sp_q    <= sp_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      fetch_gnt = 1'b0;
      data_gnt  = 1'b0;
      stk_gnt   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      owner_d   = OWN_NONE;
      sp_d      = sp_q;
      wait_d    = '0;
      err_d     = 1'b0;
      push_ok   = psh & ~pop & (sp_q != SP_FULL);
      pop_ok    = pop & ~psh & (sp_q != SP_INIT);
      if (reset) begin
         if (fetch_req && wait_q == WAIT_MAX) begin
            fetch_gnt = 1'b1;
         end else if (push_ok) begin
            stk_gnt   = 1'b1;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp_q;
            mem_wdata = stk_wdata;
            sp_d      = sp_q - 1'b1;
         end else if (pop_ok) begin
            stk_gnt  = 1'b1;
            mem_en   = 1'b1;
            mem_addr = sp_q + 1'b1;
            sp_d     = sp_q + 1'b1;
            owner_d  = OWN_STK;
         end else if (data_req) begin
            data_gnt  = 1'b1;
            mem_en    = 1'b1;
            mem_we    = data_we;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            owner_d   = data_we ? OWN_NONE : OWN_DATA;
         end else if (fetch_req) begin
            fetch_gnt = 1'b1;
         end
         if (fetch_gnt) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
            owner_d  = OWN_FETCH;
         end
         // a legal stack op merely preempted by a forced fetch is not an error
         err_d = (psh | pop) & ~(push_ok | pop_ok);
         if (fetch_req && !fetch_gnt)
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      end
   end

   // gating with reset drops a pending valid in the cycle reset goes low
   assign fetch_valid = reset & (owner_q == OWN_FETCH);
   assign data_valid  = reset & (owner_q == OWN_DATA);
   assign stk_valid   = reset & (owner_q == OWN_STK);
   assign stk_err     = reset & err_q;
   assign SP          = sp_q;
   assign rdata       = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives requests, checks grants inline and
// checks tagged read data through an expected-response queue popped by a monitor.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        fetch_req;
   logic [9:0]  fetch_addr;
   logic        fetch_gnt, fetch_valid;
   logic        data_req, data_we;
   logic [9:0]  data_addr;
   logic [15:0] data_wdata;
   logic        data_gnt, data_valid;
   logic        psh, pop;
   logic [15:0] stk_wdata;
   logic        stk_gnt, stk_valid, stk_err;
   logic [9:0]  SP;
   logic [15:0] rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   logic [15:0] mem [1024];
   logic [33:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_gnt(data_gnt), .data_valid(data_valid),
      .psh(psh), .pop(pop), .stk_wdata(stk_wdata), .stk_gnt(stk_gnt), .stk_valid(stk_valid),
      .stk_err(stk_err), .SP(SP), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // synchronous memory model, preloaded with C000+address
   initial for (int i = 0; i < 1024; i++) mem[i] = 16'hC000 + 16'(i);
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic expect_rd(input logic [1:0] tag, input logic [15:0] data);
      exp_q.push_back({16'(cyc + 1), tag, data});
   endtask

   function automatic logic [4:0] gv();
      return {fetch_gnt, data_gnt, stk_gnt, mem_en, mem_we};
   endfunction

   // scoreboard monitor: tags are 1=fetch, 2=data, 3=stack
   always @(negedge clk) begin
      logic [2:0]  v;
      logic [1:0]  tag;
      logic [33:0] e;
      v = {fetch_valid, data_valid, stk_valid};
      if (v != 3'b000) begin
         chk("valid_onehot", 34'($countones(v)), 34'd1);
         tag = fetch_valid ? 2'd1 : (data_valid ? 2'd2 : 2'd3);
         if (exp_q.size() == 0) begin
            chk("valid_unexpected", {16'h0, tag, rdata}, 34'd0);
         end else begin
            e = exp_q.pop_front();
            chk("valid_tag_rdata", {16'h0, tag, rdata}, {16'h0, e[17:0]});
         end
      end else if (exp_q.size() > 0 && int'(exp_q[0][33:18]) <= cyc) begin
         e = exp_q.pop_front();
         chk("valid_missing", 34'd0, {16'h0, e[17:0]});
      end
   end

   initial begin
      reset = 1'b0; fetch_req = 1'b1; fetch_addr = 10'h020;
      data_req = 1'b1; data_we = 1'b0; data_addr = 10'h010; data_wdata = 16'h0;
      psh = 1'b1; pop = 1'b0; stk_wdata = 16'h0;

      // reset with all requesters active
      tick(); chk("rst_gnt0", 34'(gv()), 34'd0);
      tick(); chk("rst_gnt1", 34'(gv()), 34'd0);
      chk("rst_sp", 34'(SP), 34'h3FF);
      chk("rst_err", 34'(stk_err), 34'd0);
      reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; psh = 1'b0;
      settle();
      chk("idle_gnt", 34'(gv()), 34'd0);
      chk("idle_valid", 34'({fetch_valid, data_valid, stk_valid}), 34'd0);

      // push A5A5 then pop it back
      tick(); psh = 1'b1; stk_wdata = 16'hA5A5; settle();
      chk("push_gnt", 34'(gv()), 34'b00111);
      chk("push_addr", 34'(mem_addr), 34'h3FF);
      chk("push_wdata", 34'(mem_wdata), 34'hA5A5);
      tick(); psh = 1'b0; chk("push_sp", 34'(SP), 34'h3FE);
      pop = 1'b1; settle();
      chk("pop_gnt", 34'(gv()), 34'b00110);
      chk("pop_addr", 34'(mem_addr), 34'h3FF);
      expect_rd(2'd3, 16'hA5A5);
      tick(); pop = 1'b0; chk("pop_sp", 34'(SP), 34'h3FF);

      // underflow
      pop = 1'b1; settle();
      chk("uflow_gnt", 34'(gv()), 34'd0);
      tick(); pop = 1'b0; settle();
      chk("uflow_err", 34'(stk_err), 34'd1);
      chk("uflow_sp", 34'(SP), 34'h3FF);
      tick(); chk("uflow_err_pulse", 34'(stk_err), 34'd0);

      // psh and pop together
      psh = 1'b1; pop = 1'b1; settle();
      chk("both_gnt", 34'(gv()), 34'd0);
      tick(); psh = 1'b0; pop = 1'b0; settle();
      chk("both_err", 34'(stk_err), 34'd1);
      chk("both_sp", 34'(SP), 34'h3FF);

      // fill slots 3FF..380
      for (int i = 0; i < 128; i++) begin
         tick(); psh = 1'b1; stk_wdata = 16'h1000 + 16'(i); settle();
         chk("fill_gnt", {16'h0, 5'(gv()), 3'd0, mem_addr}, {16'h0, 5'b00111, 3'd0, 10'(10'h3FF - i)});
      end
      tick(); stk_wdata = 16'hDEAD; settle();
      chk("full_sp", 34'(SP), 34'h37F);
      chk("oflow_gnt", 34'(gv()), 34'd0);
      tick(); psh = 1'b0; settle();
      chk("oflow_err", 34'(stk_err), 34'd1);
      chk("oflow_sp", 34'(SP), 34'h37F);
      pop = 1'b1; settle();
      chk("top_pop_addr", 34'(mem_addr), 34'h380);
      expect_rd(2'd3, 16'h107F);
      tick(); pop = 1'b0; chk("top_pop_sp", 34'(SP), 34'h380);

      // fetch vs data contention: three data grants then a forced fetch
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         fetch_req = 1'b1; fetch_addr = 10'h020; data_req = 1'b1; data_addr = 10'h010;
         settle();
         if (i % 4 == 3) begin
            chk("contend_fetch", {16'h0, 5'(gv()), 3'd0, mem_addr}, {16'h0, 5'b10010, 3'd0, 10'h020});
            expect_rd(2'd1, 16'hC020);
         end else begin
            chk("contend_data", {16'h0, 5'(gv()), 3'd0, mem_addr}, {16'h0, 5'b01010, 3'd0, 10'h010});
            expect_rd(2'd2, 16'hC010);
         end
      end
      tick(); fetch_req = 1'b0; data_req = 1'b0;

      // data store then load of the same word
      tick(); data_req = 1'b1; data_we = 1'b1; data_addr = 10'h030; data_wdata = 16'h1234; settle();
      chk("store_gnt", 34'(gv()), 34'b01011);
      chk("store_wdata", 34'(mem_wdata), 34'h1234);
      tick(); data_we = 1'b0; settle();
      chk("load_gnt", 34'(gv()), 34'b01010);
      expect_rd(2'd2, 16'h1234);
      tick(); data_req = 1'b0;

      // simultaneous push, data and fetch with the wait counter clear
      tick(); psh = 1'b1; stk_wdata = 16'hBEEF; data_req = 1'b1; data_addr = 10'h010;
      fetch_req = 1'b1; fetch_addr = 10'h020; settle();
      chk("prio_stk", 34'(gv()), 34'b00111);
      chk("prio_stk_addr", 34'(mem_addr), 34'h380);
      tick(); psh = 1'b0; settle();
      chk("prio_data", 34'(gv()), 34'b01010);
      expect_rd(2'd2, 16'hC010);
      tick(); data_req = 1'b0; settle();
      chk("prio_fetch", 34'(gv()), 34'b10010);
      expect_rd(2'd1, 16'hC020);
      tick(); fetch_req = 1'b0; settle();
      chk("prio_sp", 34'(SP), 34'h37F);

      // reset right after a granted load drops its valid
      tick(); data_req = 1'b1; data_addr = 10'h010; settle();
      chk("rst_mid_gnt", 34'(gv()), 34'b01010);
      tick(); data_req = 1'b0; fetch_req = 1'b1; psh = 1'b1; reset = 1'b0; settle();
      chk("rst_mid_valid", 34'(data_valid), 34'd0);
      chk("rst_mid_nogrant", 34'(gv()), 34'd0);
      tick(); settle();
      chk("rst_mid_sp", 34'(SP), 34'h3FF);
      chk("rst_mid_nogrant2", 34'(gv()), 34'd0);
      tick(); reset = 1'b1; psh = 1'b0; fetch_addr = 10'h005; settle();
      chk("post_rst_fetch", 34'(gv()), 34'b10010);
      expect_rd(2'd1, 16'hC005);
      tick(); fetch_req = 1'b0;

      repeat (3) tick();
      chk("queue_drained", 34'(exp_q.size()), 34'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
